// File: rtl/booth_radix4_multiplier.sv
// booth_radix4_multiplier
// Sequential radix-4 (modified) Booth multiplier. Retires two multiplier bits
// per clock for signed or unsigned operands, selected per operation, with a
// start / busy / done handshake. The product is 2*DATA_WIDTH bits and exact.
//
// Optional feature macro: BOOTH_EARLY_EXIT_EN
//   defined   - an operation finishes on the first step after which every
//               remaining recoding would be +0 (latency 1..N edges).
//   undefined - fixed latency of N = DATA_WIDTH/2 + 1 edges; no exit logic.
module booth_radix4_multiplier #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    is_signed,
    input  logic [DATA_WIDTH-1:0]   multiplicand,
    input  logic [DATA_WIDTH-1:0]   multiplier,
    output logic                    busy,
    output logic                    done,
    output logic [2*DATA_WIDTH-1:0] product
);

    // Operands are extended to EXT_W bits so signed and unsigned share one
    // datapath; A and Q carry one more bit so that +/-2M cannot overflow A.
    localparam int EXT_W   = DATA_WIDTH + 2;
    localparam int REG_W   = EXT_W + 1;
    localparam int PAIR_W  = 2 * REG_W;
    localparam int N_STEPS = EXT_W / 2;
    localparam int CNT_W   = $clog2(N_STEPS + 1);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(N_STEPS);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic {
        IDLE,
        CALC
    } state_t;

    state_t                  state_q,   state_d;
    logic [REG_W-1:0]        a_q,       a_d;
    logic [REG_W-1:0]        q_q,       q_d;
    logic [REG_W-1:0]        m_q,       m_d;
    logic [CNT_W-1:0]        count_q,   count_d;
    logic                    done_q,    done_d;
    logic [2*DATA_WIDTH-1:0] product_q, product_d;

    logic [REG_W-1:0]        m_ext;
    logic [REG_W-1:0]        q_init;
    logic [REG_W-1:0]        addend;
    logic [REG_W-1:0]        sum;
    logic signed [PAIR_W-1:0] pair_s;
    logic signed [PAIR_W-1:0] step_pair;
    logic                    last_step;

    // Operand extension: sign bit replicated only for signed operations.
    always_comb begin
        m_ext  = {{3{is_signed & multiplicand[DATA_WIDTH-1]}}, multiplicand};
        q_init = {{2{is_signed & multiplier[DATA_WIDTH-1]}}, multiplier, 1'b0};
    end

    // Booth recoding of {Q1,Q0,Q-1} and the accumulator add.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned and infers a latch.
        addend = '0;
        unique case (q_q[2:0])
            3'b001, 3'b010: addend = m_q;
            3'b011:         addend = m_q << 1;
            3'b100:         addend = -(m_q << 1);
            3'b101, 3'b110: addend = -m_q;
            default:        addend = '0;
        endcase
        sum    = a_q + addend;
        pair_s = {sum, q_q};
    end

`ifdef BOOTH_EARLY_EXIT_EN
    logic all_zero;
    logic all_one;
    logic early_exit;

    // Look-ahead: after this step the unprocessed bits are q_q[2*count:2]
    // (q_q[2] becomes the new Q-1). If they are uniform, every later recoding
    // is +0, so this step also applies the remaining 2*(count-1) shift.
    always_comb begin
        all_zero = 1'b1;
        all_one  = 1'b1;
        for (int i = 2; i < REG_W; i++) begin
            if (i <= 2 * int'(count_q)) begin
                all_zero = all_zero & ~q_q[i];
                all_one  = all_one & q_q[i];
            end
        end
        early_exit = all_zero | all_one;
        step_pair  = early_exit ? (pair_s >>> (2 * int'(count_q))) : (pair_s >>> 2);
        last_step  = early_exit | (count_q == CNT_ONE);
    end
`else
    // Fixed-latency step: arithmetic shift of {A,Q} by two bits.
    always_comb begin
        step_pair = pair_s >>> 2;
        last_step = (count_q == CNT_ONE);
    end
`endif

    // Next-state logic for the control FSM and the datapath registers.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        q_d       = q_q;
        m_d       = m_q;
        count_d   = count_q;
        done_d    = 1'b0;
        product_d = product_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = '0;
                    q_d     = q_init;
                    m_d     = m_ext;
                    count_d = CNT_LOAD;
                    state_d = CALC;
                end
            end
            CALC: begin
                {a_d, q_d} = step_pair;
                count_d    = count_q - CNT_ONE;
                if (last_step) begin
                    // Low 2W bits of the shifted pair, skipping Q-1.
                    product_d = step_pair[2*DATA_WIDTH:1];
                    count_d   = '0;
                    done_d    = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register with synchronous reset that discards any in-flight result.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (reset) begin
            state_q   <= IDLE;
            a_q       <= '0;
            q_q       <= '0;
            m_q       <= '0;
            count_q   <= '0;
            done_q    <= 1'b0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            q_q       <= q_d;
            m_q       <= m_d;
            count_q   <= count_d;
            done_q    <= done_d;
            product_q <= product_d;
        end
    end

    assign busy    = (state_q == CALC);
    assign done    = done_q;
    assign product = product_q;

endmodule

// File: tb/tb_booth_radix4_multiplier.sv
// Self-checking bench for booth_radix4_multiplier (DATA_WIDTH = 32).
// Inputs change and outputs are sampled on the falling clock edge.
// Build with BOOTH_EARLY_EXIT_EN defined to exercise the early-exit variant.
module tb_booth_radix4_multiplier;

    localparam int W = 32;

    logic           clk;
    logic           reset;
    logic           start;
    logic           is_signed;
    logic [W-1:0]   multiplicand;
    logic [W-1:0]   multiplier;
    logic           busy;
    logic           done;
    logic [2*W-1:0] product;

    int tests_run;
    int tests_failed;

    booth_radix4_multiplier #(.DATA_WIDTH(W)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .is_signed    (is_signed),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .done         (done),
        .product      (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Launch one operation and wait (bounded) for done. Returns the product,
    // the number of edges after the accept edge, and how many cycles busy was
    // low while the operation was still in flight.
    task automatic run_op(input logic [W-1:0] m, input logic [W-1:0] q, input logic s,
                          output logic [2*W-1:0] p, output int lat, output int busy_low);
        @(negedge clk);
        multiplicand = m;
        multiplier   = q;
        is_signed    = s;
        start        = 1'b1;
        @(posedge clk);               // edge 0: accept
        @(negedge clk);
        start        = 1'b0;
        multiplicand = $urandom();    // operands are don't-care after accept
        multiplier   = $urandom();
        is_signed    = 1'b1;
        lat      = 0;
        busy_low = 0;
        while (!done && lat < 60) begin
            if (busy !== 1'b1) busy_low++;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        p = product;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        is_signed = 1'b0;
        multiplicand = '0;
        multiplier = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", busy); end
        tests_run++;
        if (done !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %b want 0", done); end
        tests_run++;
        if (product !== 64'h0) begin tests_failed++; $display("FAIL reset_product: got %h want 0", product); end
    endtask

    task automatic test_signed_small();
        logic [2*W-1:0] p;
        int lat, busy_low;
        run_op(32'hFFFF_FFF9, 32'h0000_0003, 1'b1, p, lat, busy_low);
        tests_run++;
        if (p !== 64'hFFFF_FFFF_FFFF_FFEB) begin tests_failed++; $display("FAIL neg7x3_product: got %h want ffffffffffffffeb", p); end
        tests_run++;
        if (lat !== 17) begin tests_failed++; $display("FAIL neg7x3_latency: got %0d want 17", lat); end
        tests_run++;
        if (busy_low !== 0) begin tests_failed++; $display("FAIL neg7x3_busy_high: busy low in %0d cycles want 0", busy_low); end
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL neg7x3_busy_done_cycle: got %b want 0", busy); end
        @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (done !== 1'b0) begin tests_failed++; $display("FAIL neg7x3_done_one_cycle: got %b want 0", done); end
        tests_run++;
        if (product !== 64'hFFFF_FFFF_FFFF_FFEB) begin tests_failed++; $display("FAIL neg7x3_product_held: got %h", product); end
    endtask

    task automatic test_extremes();
        logic [W-1:0]   m_vec [5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF};
        logic [W-1:0]   q_vec [5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000, 32'h0000_0002};
        logic           s_vec [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [2*W-1:0] e_vec [5] = '{64'hFFFF_FFFE_0000_0001, 64'h0000_0000_0000_0001,
                                      64'h4000_0000_0000_0000, 64'hC000_0000_8000_0000,
                                      64'h0000_0001_FFFF_FFFE};
        logic [2*W-1:0] p;
        int lat, busy_low;
        for (int i = 0; i < 5; i++) begin
            run_op(m_vec[i], q_vec[i], s_vec[i], p, lat, busy_low);
            tests_run++;
            if (done !== 1'b1 || p !== e_vec[i]) begin
                tests_failed++;
                $display("FAIL extreme_%0d: done %b product %h want %h", i, done, p, e_vec[i]);
            end
        end
    endtask

    task automatic test_overlap_ignored();
        logic [2*W-1:0] p;
        int e;
        @(negedge clk);
        multiplicand = 32'd2;
        multiplier   = 32'd3;
        is_signed    = 1'b0;
        start        = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        e = 0;
        while (!done && e < 60) begin
            // Request a new operation at edges 5..7 while still busy.
            start        = (e >= 4 && e <= 6);
            multiplicand = 32'd9;
            multiplier   = 32'hFFFF_FFF7;
            is_signed    = 1'b1;
            @(posedge clk);
            e++;
            @(negedge clk);
        end
        start = 1'b0;
        p = product;
        tests_run++;
        if (p !== 64'd6) begin tests_failed++; $display("FAIL overlap_product: got %h want 6", p); end
        tests_run++;
        if (e !== 17) begin tests_failed++; $display("FAIL overlap_latency: got %0d want 17", e); end
        @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            tests_failed++; $display("FAIL overlap_no_relaunch: busy %b done %b want 0 0", busy, done);
        end
    endtask

    task automatic test_reset_mid_op();
        logic [2*W-1:0] p;
        int lat, busy_low;
        @(negedge clk);
        multiplicand = 32'd100;
        multiplier   = 32'd200;
        is_signed    = 1'b0;
        start        = 1'b1;
        @(posedge clk);               // edge 0
        @(negedge clk);
        start = 1'b0;
        repeat (4) begin @(posedge clk); @(negedge clk); end
        start        = 1'b1;          // sampled at edges 5..7
        multiplicand = 32'd11;
        multiplier   = 32'd13;
        @(posedge clk);               // edge 5
        @(negedge clk);
        tests_run++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            tests_failed++; $display("FAIL midop_start_ignored: busy %b done %b want 1 0", busy, done);
        end
        @(posedge clk);               // edge 6
        @(posedge clk);               // edge 7
        @(negedge clk);
        reset = 1'b1;
        start = 1'b0;
        @(posedge clk);               // edge 8: reset
        @(negedge clk);
        reset = 1'b0;
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL midop_reset_busy: got %b want 0", busy); end
        tests_run++;
        if (done !== 1'b0) begin tests_failed++; $display("FAIL midop_reset_done: got %b want 0", done); end
        tests_run++;
        if (product !== 64'h0) begin tests_failed++; $display("FAIL midop_reset_product: got %h want 0", product); end
        run_op(32'd5, 32'd6, 1'b0, p, lat, busy_low);
        tests_run++;
        if (p !== 64'd30) begin tests_failed++; $display("FAIL after_reset_product: got %h want 1e", p); end
        tests_run++;
        if (lat !== 17) begin tests_failed++; $display("FAIL after_reset_latency: got %0d want 17", lat); end
    endtask

    task automatic test_back_to_back();
        int e;
        int hold_bad;
        @(negedge clk);
        multiplicand = 32'd2;
        multiplier   = 32'd3;
        is_signed    = 1'b0;
        start        = 1'b1;
        @(posedge clk);               // edge 0: first accept
        @(negedge clk);
        multiplicand = 32'd4;         // start stays high
        multiplier   = 32'd5;
        e = 0;
        while (!done && e < 60) begin
            @(posedge clk);
            e++;
            @(negedge clk);
        end
        tests_run++;
        if (e !== 17 || product !== 64'd6) begin
            tests_failed++; $display("FAIL b2b_first: edge %0d product %h want 17 6", e, product);
        end
        @(posedge clk);               // edge 18: second accept
        e++;
        @(negedge clk);
        tests_run++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            tests_failed++; $display("FAIL b2b_reaccept: done %b busy %b want 0 1", done, busy);
        end
        hold_bad = 0;
        while (!done && e < 90) begin
            if (product !== 64'd6) hold_bad++;
            @(posedge clk);
            e++;
            @(negedge clk);
        end
        start = 1'b0;
        tests_run++;
        if (hold_bad !== 0) begin tests_failed++; $display("FAIL b2b_hold: product changed in %0d cycles want 0", hold_bad); end
        tests_run++;
        if (e !== 35 || product !== 64'd20) begin
            tests_failed++; $display("FAIL b2b_second: edge %0d product %h want 35 14", e, product);
        end
        @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            tests_failed++; $display("FAIL b2b_idle: done %b busy %b want 0 0", done, busy);
        end
    endtask

`ifdef BOOTH_EARLY_EXIT_EN
    task automatic test_early_exit();
        logic [W-1:0]   q_vec [4] = '{32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0010};
        logic           s_vec [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic [2*W-1:0] e_vec [4] = '{64'h0, 64'h0000_0000_1234_5678,
                                      64'hFFFF_FFFF_EDCB_A988, 64'h0000_0001_2345_6780};
        int             l_vec [4] = '{1, 1, 1, 3};
        logic [2*W-1:0] p;
        int lat, busy_low;
        for (int i = 0; i < 4; i++) begin
            run_op(32'h1234_5678, q_vec[i], s_vec[i], p, lat, busy_low);
            tests_run++;
            if (p !== e_vec[i]) begin tests_failed++; $display("FAIL early_%0d_product: got %h want %h", i, p, e_vec[i]); end
            tests_run++;
            if (lat !== l_vec[i]) begin tests_failed++; $display("FAIL early_%0d_latency: got %0d want %0d", i, lat, l_vec[i]); end
        end
    endtask
`endif

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
`ifdef BOOTH_EARLY_EXIT_EN
        test_extremes();
        test_early_exit();
`else
        test_signed_small();
        test_extremes();
        test_overlap_ignored();
        test_reset_mid_op();
        test_back_to_back();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
